// File: rtl/lfsr_pkg.sv
// Shared types and default constants for the LFSR range generator.
package lfsr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      HOLD = 2'd2
   } fsm_t;

   localparam logic [7:0]  TAP_MASK_8  = 8'hB8;
   localparam logic [15:0] TAP_MASK_16 = 16'hB400;
   localparam logic [15:0] SEED_16     = 16'hACE1;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register: shift left, parity of tapped bits enters at bit 0.
// A zero load value falls back to INIT_SEED so the register never locks up.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] TAP_MASK  = WIDTH'(TAP_MASK_16),
   parameter logic [WIDTH-1:0] INIT_SEED = WIDTH'(SEED_16)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] state
);

   logic [WIDTH-1:0] r_state;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_seed;

   assign w_next = {r_state[WIDTH-2:0], ^(r_state & TAP_MASK)};
   assign w_seed = (load_val == '0) ? INIT_SEED : load_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= INIT_SEED;
      end else if (load) begin
         r_state <= w_seed;
      end else if (en) begin
         r_state <= w_next;
      end
   end

   assign state = r_state;

endmodule

// File: rtl/lfsr_range_gen.sv
// Request/response wrapper that maps LFSR output into 0..RANGE-1.
// Define LFSR_RANGE_REJECT_EN for rejection sampling; otherwise a one-cycle scaled draw.
module lfsr_range_gen
   import lfsr_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] TAP_MASK  = WIDTH'(TAP_MASK_16),
   parameter logic [WIDTH-1:0] INIT_SEED = WIDTH'(SEED_16),
   parameter int               RANGE     = 9,
   parameter int               OUT_W     = 4,
   parameter int               MAX_TRIES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             req_valid,
   output logic             req_ready,
   output logic             rsp_valid,
   output logic [OUT_W-1:0] rsp_data,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] state,
   output logic             fallback
);

   fsm_t             r_fsm;
   logic             r_req_ready;
   logic             r_rsp_valid;
   logic [OUT_W-1:0] r_rsp_data;
   logic [WIDTH-1:0] w_state;
   logic [OUT_W-1:0] w_cand;
   logic             w_step;

`ifdef LFSR_RANGE_REJECT_EN
   localparam int             CW       = OUT_W + 1;
   localparam int             TW       = $clog2(MAX_TRIES + 1);
   localparam logic [TW-1:0]  TRY_LAST = TW'(MAX_TRIES - 1);

   logic          r_fallback;
   logic [TW-1:0] r_tries;
   logic          w_in_range;

   assign w_in_range = ({1'b0, w_cand} < CW'(RANGE));
   assign fallback   = r_fallback;
`else
   localparam int PW = 2 * OUT_W + 1;

   assign fallback = 1'b0;
`endif

   // DRAW consumes one LFSR step per cycle whether or not free-run is enabled
   assign w_step = (r_fsm == DRAW) | en;
   assign w_cand = w_state[OUT_W-1:0];

   lfsr_core #(
      .WIDTH     (WIDTH),
      .TAP_MASK  (TAP_MASK),
      .INIT_SEED (INIT_SEED)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .en       (w_step),
      .load     (seed_load),
      .load_val (seed_in),
      .state    (w_state)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm       <= IDLE;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
`ifdef LFSR_RANGE_REJECT_EN
         r_fallback  <= 1'b0;
         r_tries     <= '0;
`endif
      end else begin
`ifdef LFSR_RANGE_REJECT_EN
         r_fallback <= 1'b0;
`endif
         case (r_fsm)
            IDLE: begin
               if (req_valid) begin
                  r_fsm       <= DRAW;
                  r_req_ready <= 1'b0;
`ifdef LFSR_RANGE_REJECT_EN
                  r_tries     <= '0;
`endif
               end
            end
            DRAW: begin
               // A seed load restarts the draw from the new seed on the next cycle
               if (!seed_load) begin
`ifdef LFSR_RANGE_REJECT_EN
                  if (w_in_range) begin
                     r_rsp_data  <= w_cand;
                     r_rsp_valid <= 1'b1;
                     r_fsm       <= HOLD;
                  end else if (r_tries == TRY_LAST) begin
                     r_rsp_data  <= w_cand - OUT_W'(RANGE);
                     r_fallback  <= 1'b1;
                     r_rsp_valid <= 1'b1;
                     r_fsm       <= HOLD;
                  end else begin
                     r_tries <= r_tries + TW'(1);
                  end
`else
                  r_rsp_data  <= OUT_W'((PW'(w_cand) * PW'(RANGE)) >> OUT_W);
                  r_rsp_valid <= 1'b1;
                  r_fsm       <= HOLD;
`endif
               end
`ifdef LFSR_RANGE_REJECT_EN
               else begin
                  r_tries <= '0;
               end
`endif
            end
            HOLD: begin
               if (rsp_ready) begin
                  r_fsm       <= IDLE;
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
               end
            end
            default: r_fsm <= IDLE;
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign state     = w_state;

endmodule
